instr_mem_axi_rd_slave: RTL and testbench
=========================================

INSTR_MEM_AXI_RD_SLAVE -- requirements
Module: instr_mem_axi_rd_slave

Interface
REQ-001 The module SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, byte base address of the memory window.
REQ-002 The module SHALL have parameter C_MEM_AW, default 12, memory depth in 128-bit words (2^C_MEM_AW).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The module SHALL have port s_axi_arid, input, 4 bits, read transaction ID.
REQ-006 The module SHALL have port s_axi_araddr, input, 32 bits, byte start address.
REQ-007 The module SHALL have port s_axi_arlen, input, 8 bits, beats minus 1.
REQ-008 The module SHALL have port s_axi_arsize, input, 3 bits, beat size.
REQ-009 The module SHALL have port s_axi_arburst, input, 2 bits, burst type.
REQ-010 The module SHALL have ports s_axi_arlock[0:0], arcache[3:0], arprot[2:0] and arqos[3:0], inputs, accepted and ignored.
REQ-011 The module SHALL have port s_axi_arvalid, input, 1 bit, and port s_axi_arready, output, 1 bit, forming the AR handshake.
REQ-012 The module SHALL have the following outputs: s_axi_rid (4 bits), s_axi_rdata (128 bits), s_axi_rresp (2 bits), s_axi_rlast (1 bit) and s_axi_rvalid (1 bit), forming the R channel.
REQ-013 The module SHALL have port s_axi_rready, input, 1 bit, R-channel backpressure.
REQ-014 The module SHALL have ports mem_en, output, 1 bit, and mem_addr, output, C_MEM_AW bits, driving the RAM read port.
REQ-015 The module SHALL have port mem_rdata, input, 128 bits, RAM data valid exactly one clock after mem_en.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST. IDLE drives arready=1. An AR handshake captures id, word address ((araddr-C_BASE_ADDR)>>4), a beat counter of arlen+1, burst type and an error class, then moves the FSM to BURST. BURST drives arready=0.
REQ-017 Only one transaction SHALL be outstanding at a time.
REQ-018 The FSM SHALL return to IDLE on the clock after the R handshake with rlast=1, and arready SHALL be 1 again in that cycle.
REQ-019 The error class SHALL be computed as follows:
- arsize!=3'b100 or arburst in {WRAP, 2'b11}: every beat is SLVERR (2'b10).
- Otherwise, any beat whose word address is >= 2^C_MEM_AW, or whose byte address is below C_BASE_ADDR, is DECERR (2'b11).
- Otherwise, the beat is OKAY (2'b00).
REQ-020 Error beats SHALL carry rdata=0, SHALL NOT assert mem_en, and SHALL still occupy the full arlen+1 beats in order.
REQ-021 For INCR bursts the word address SHALL increment by 1 per issued beat; for FIXED bursts it SHALL stay constant.
REQ-022 Beats SHALL be issued to the RAM only when (FIFO occupancy + reads in flight − pop this cycle) < 2. Returning mem_rdata SHALL be written into a 2-entry R FIFO together with rid, rresp and rlast.
REQ-023 Timing and ordering SHALL meet the following:
- rvalid rises exactly 2 clocks after the AR handshake edge.
- With rready held high, one beat is transferred per clock with no bubbles.
- rlast=1 is asserted only on beat arlen+1.
REQ-024 While rvalid=1 and rready=0, rdata, rid, rresp and rlast SHALL be held stable, and no FIFO entry SHALL be overwritten or dropped.
REQ-025 An arlen of 0 SHALL produce a single beat with rlast=1.
REQ-026 An arvalid seen while in BURST SHALL be left pending without being accepted.

Reset
REQ-027 While rst=1, the module SHALL hold the FSM in IDLE, drive arready=0, clear the FIFO and in-flight count, and drive rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_en=0 and mem_addr=0.
REQ-028 arready SHALL become 1 on the first clock after rst is released.
REQ-029 A reset asserted mid-burst SHALL abort the burst; RAM data in flight SHALL be discarded and SHALL NOT appear after reset is released.

Structure
REQ-030 A shared package SHALL hold the RESP codes (OKAY/SLVERR/DECERR), the BURST codes (FIXED/INCR/WRAP), the FSM state encoding and the beat size constant 3'b100.
REQ-031 The R FIFO SHALL be a separate sub-module, rd_skid_fifo: 2 entries, 128+4+2+1 bits wide, with push/pop/full/empty, reset by rst.

Verification
REQ-032 The bench SHALL cover the following INCR burst case:
- Stimulus: araddr=C_BASE_ADDR+0x40, arlen=3, arsize=4, id=5, RAM word n preloaded with n, rready=1.
- Response: rdata 4,5,6,7 on consecutive clocks; rid=5; rresp=OKAY; rlast only on the 4th beat; rvalid first seen 2 clocks after the AR handshake.
REQ-033 The bench SHALL cover the following backpressure case:
- Stimulus: arlen=7, rready toggling 1/0 every clock.
- Response: 8 beats in order with no loss or duplication; outputs stable while stalled.
REQ-034 The bench SHALL cover the following FIXED burst case:
- Stimulus: arburst=FIXED, arlen=2, address of word 9.
- Response: three beats all carrying RAM word 9.
REQ-035 The bench SHALL cover the following error case:
- Stimulus: arsize=3'b010, arlen=1.
- Response: two SLVERR beats with rdata=0 and mem_en never asserted.
- Stimulus: an INCR burst starting at word 2^C_MEM_AW−2 with arlen=3.
- Response: OKAY, OKAY, DECERR, DECERR.
REQ-036 The bench SHALL cover back-to-back transactions: a second arvalid held throughout the first burst SHALL be accepted exactly 1 clock after the first burst's rlast handshake.
REQ-037 The bench SHALL cover the following reset case:
- Stimulus: rst pulsed for 1 clock after beat 2 of an arlen=7 burst.
- Response: rvalid=0 immediately; no stale beats after release; a new arlen=0 read returns a single correct beat.

Source files
------------

// File: rtl/instr_mem_axi_rd_slave_pkg.sv
// Shared types and codes for the instruction memory AXI read slave.
// Response, burst and beat-size encodings plus FSM state.
package instr_mem_axi_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_16B = 3'b100;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_beat_t;

  localparam int R_W = $bits(r_beat_t);

endpackage

// File: rtl/instr_mem_axi_rd_slave_fifo.sv
// Two-entry R channel FIFO sitting between the RAM
// return path and the AXI R outputs.
module rd_skid_fifo
  import instr_mem_axi_rd_slave_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [R_W-1:0] din,
  input  logic           pop,
  output logic [R_W-1:0] dout,
  output logic           full,
  output logic           empty
);

  logic [R_W-1:0] mem0;
  logic [R_W-1:0] mem1;
  logic           wp;
  logic           rp;
  logic [1:0]     cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0 <= '0;
      mem1 <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        if (wp) mem1 <= din;
        else    mem0 <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = rp ? mem1 : mem0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/instr_mem_axi_rd_slave.sv
// AXI4 read-only slave in front of a 128-bit synchronous
// instruction RAM with one-cycle read latency.
module instr_mem_axi_rd_slave
  import instr_mem_axi_rd_slave_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int          C_MEM_AW    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [0:0]          s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [3:0]          s_axi_rid,
  output logic [127:0]        s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                mem_en,
  output logic [C_MEM_AW-1:0] mem_addr,
  input  logic [127:0]        mem_rdata
);

  localparam logic [28:0] WORD_LIM = 29'(1) << C_MEM_AW;

  state_t      state;
  logic [3:0]  b_id;
  logic [28:0] b_waddr;
  logic [8:0]  b_left;
  logic [1:0]  b_burst;
  logic        b_slverr;
  logic        b_below;

  logic        p_valid;
  logic [3:0]  p_id;
  logic [1:0]  p_resp;
  logic        p_last;

  logic [31:0] ar_off;
  logic        ar_hs;
  logic        pop;
  logic        issue;
  logic [1:0]  occ;
  logic [2:0]  occ_sum;
  logic [1:0]  beat_resp;
  logic        f_full;
  logic        f_empty;
  r_beat_t     f_in;
  r_beat_t     f_out;
  logic        unused;

  assign ar_off = s_axi_araddr - C_BASE_ADDR;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign pop    = s_axi_rvalid & s_axi_rready;

  // Credit check keeps FIFO entries plus in-flight reads within 2
  assign occ     = f_full ? 2'd2 : (f_empty ? 2'd0 : 2'd1);
  assign occ_sum = {1'b0, occ} + {2'b0, p_valid} - {2'b0, pop};
  assign issue   = (state == S_BURST) && (b_left != 9'd0)
                && (occ_sum < 3'd2);

  always_comb begin
    beat_resp = RESP_OKAY;
    unique case (1'b1)
      b_slverr:                       beat_resp = RESP_SLVERR;
      b_below || b_waddr >= WORD_LIM: beat_resp = RESP_DECERR;
      default:                        beat_resp = RESP_OKAY;
    endcase
  end

  assign mem_en   = issue && (beat_resp == RESP_OKAY);
  assign mem_addr = b_waddr[C_MEM_AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      s_axi_arready <= 1'b0;
      b_id          <= '0;
      b_waddr       <= '0;
      b_left        <= '0;
      b_burst       <= '0;
      b_slverr      <= 1'b0;
      b_below       <= 1'b0;
      p_valid       <= 1'b0;
      p_id          <= '0;
      p_resp        <= '0;
      p_last        <= 1'b0;
    end else begin
      p_valid <= issue;
      if (issue) begin
        p_id   <= b_id;
        p_resp <= beat_resp;
        p_last <= (b_left == 9'd1);
      end
      unique case (state)
        S_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs) begin
            state         <= S_BURST;
            s_axi_arready <= 1'b0;
            b_id          <= s_axi_arid;
            b_waddr       <= {1'b0, ar_off[31:4]};
            b_left        <= {1'b0, s_axi_arlen} + 9'd1;
            b_burst       <= s_axi_arburst;
            b_slverr      <= (s_axi_arsize != SIZE_16B)
                          || (s_axi_arburst == BURST_WRAP)
                          || (s_axi_arburst == 2'b11);
            b_below       <= (s_axi_araddr < C_BASE_ADDR);
          end
        end
        S_BURST: begin
          if (issue) begin
            b_left <= b_left - 9'd1;
            if (b_burst == BURST_INCR)
              b_waddr <= b_waddr + 29'd1;
          end
          if (pop && s_axi_rlast) begin
            state         <= S_IDLE;
            s_axi_arready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign f_in.id   = p_id;
  assign f_in.data = (p_resp == RESP_OKAY) ? mem_rdata : 128'd0;
  assign f_in.resp = p_resp;
  assign f_in.last = p_last;

  rd_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (p_valid),
    .din   (f_in),
    .pop   (pop),
    .dout  (f_out),
    .full  (f_full),
    .empty (f_empty)
  );

  assign s_axi_rvalid = ~f_empty;
  assign s_axi_rid    = f_out.id;
  assign s_axi_rdata  = f_out.data;
  assign s_axi_rresp  = f_out.resp;
  assign s_axi_rlast  = f_out.last;

  assign unused = ^{s_axi_arlock, s_axi_arcache,
                    s_axi_arprot, s_axi_arqos, ar_off[3:0]};

endmodule

// File: tb/tb_instr_mem_axi_rd_slave.sv
// Directed bench for instr_mem_axi_rd_slave with a
// behavioural one-cycle RAM holding word n = n.
module tb_instr_mem_axi_rd_slave;
  import instr_mem_axi_rd_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    s_axi_arid = '0;
  logic [31:0]   s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic [2:0]    s_axi_arsize = '0;
  logic [1:0]    s_axi_arburst = '0;
  logic [0:0]    s_axi_arlock = '0;
  logic [3:0]    s_axi_arcache = '0;
  logic [2:0]    s_axi_arprot = '0;
  logic [3:0]    s_axi_arqos = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [3:0]    s_axi_rid;
  logic [127:0]  s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_rdata;

  logic [127:0] ram [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;
  int memen_cnt = 0;
  int cyc_cnt = 0;

  instr_mem_axi_rd_slave #(
    .C_BASE_ADDR (BASE),
    .C_MEM_AW    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arlock  (s_axi_arlock),
    .s_axi_arcache (s_axi_arcache),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arqos   (s_axi_arqos),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
    if (mem_en) memen_cnt++;
    cyc_cnt++;
  end

  typedef struct {
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic [3:0]   id;
    logic [127:0] first;
    bit           step;
    int           ok;
    logic [1:0]   err;
  } vec_t;

  vec_t vt [8];

  function automatic logic [31:0] w(input int n);
    return BASE + 32'(n) * 32'd16;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Present AR, wait for acceptance, leave arvalid low
  // at the negedge following the handshake edge.
  task automatic do_ar(input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b,
                       input logic [3:0] id);
    bit got;
    @(negedge clk);
    s_axi_araddr  = a;
    s_axi_arlen   = l;
    s_axi_arsize  = s;
    s_axi_arburst = b;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_axi_arready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ar_accept", 128'(got), 128'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int m0;
    int cyc;
    logic [127:0] ed;
    logic [1:0] er;
    s_axi_rready = 1'b1;
    m0 = memen_cnt;
    do_ar(v.addr, v.len, v.size, v.burst, v.id);
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (s_axi_rvalid) break;
    end
    chk("rvalid_latency", 128'(cyc), 128'd2);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i > 0) @(negedge clk);
      if (i < v.ok) begin
        er = RESP_OKAY;
        ed = v.first + (v.step ? 128'(i) : 128'd0);
      end else begin
        er = v.err;
        ed = 128'd0;
      end
      chk("beat_rvalid", 128'(s_axi_rvalid), 128'd1);
      chk("beat_rdata", s_axi_rdata, ed);
      chk("beat_rresp", 128'(s_axi_rresp), 128'(er));
      chk("beat_rid", 128'(s_axi_rid), 128'(v.id));
      chk("beat_rlast", 128'(s_axi_rlast),
          128'(i == int'(v.len)));
    end
    @(negedge clk);
    chk("end_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("end_arready", 128'(s_axi_arready), 128'd1);
    chk("mem_en_count", 128'(memen_cnt - m0), 128'(v.ok));
  endtask

  initial begin
    int idx;
    bit stall;
    logic [127:0] pd;
    logic pl;
    int tl;
    int ta;
    int cnt;
    bit seen;

    for (int n = 0; n < (1 << AW); n++) ram[n] = 128'(n);

    vt[0] = '{w(4), 8'd3, SIZE_16B, BURST_INCR, 4'd5,
              128'd4, 1'b1, 4, RESP_OKAY};
    vt[1] = '{w(9), 8'd2, SIZE_16B, BURST_FIXED, 4'd6,
              128'd9, 1'b0, 3, RESP_OKAY};
    vt[2] = '{w(3), 8'd1, 3'b010, BURST_INCR, 4'd2,
              128'd0, 1'b0, 0, RESP_SLVERR};
    vt[3] = '{w(4094), 8'd3, SIZE_16B, BURST_INCR, 4'd11,
              128'd4094, 1'b1, 2, RESP_DECERR};
    vt[4] = '{w(100), 8'd0, SIZE_16B, BURST_INCR, 4'd3,
              128'd100, 1'b1, 1, RESP_OKAY};
    vt[5] = '{w(7), 8'd1, SIZE_16B, BURST_WRAP, 4'd4,
              128'd0, 1'b0, 0, RESP_SLVERR};
    vt[6] = '{BASE - 32'd16, 8'd0, SIZE_16B, BURST_INCR, 4'd15,
              128'd0, 1'b0, 0, RESP_DECERR};
    vt[7] = '{w(50), 8'd0, SIZE_16B, BURST_INCR, 4'd12,
              128'd50, 1'b1, 1, RESP_OKAY};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 128'(s_axi_arready), 128'd0);
    chk("rst_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("rst_rlast", 128'(s_axi_rlast), 128'd0);
    chk("rst_rresp", 128'(s_axi_rresp), 128'd0);
    chk("rst_rid", 128'(s_axi_rid), 128'd0);
    chk("rst_rdata", s_axi_rdata, 128'd0);
    chk("rst_mem_en", 128'(mem_en), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arready", 128'(s_axi_arready), 128'd1);

    for (int t = 0; t < 7; t++) run_burst(vt[t]);

    // Backpressure: rready toggles every clock
    do_ar(w(16), 8'd7, SIZE_16B, BURST_INCR, 4'd9);
    idx = 0;
    stall = 0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      if (stall) begin
        chk("bp_hold_valid", 128'(s_axi_rvalid), 128'd1);
        chk("bp_hold_data", s_axi_rdata, pd);
        chk("bp_hold_last", 128'(s_axi_rlast), 128'(pl));
      end
      s_axi_rready = c[0];
      if (s_axi_rvalid && s_axi_rready) begin
        chk("bp_data", s_axi_rdata, 128'(16 + idx));
        chk("bp_last", 128'(s_axi_rlast), 128'(idx == 7));
        idx++;
      end
      stall = s_axi_rvalid && !s_axi_rready;
      pd = s_axi_rdata;
      pl = s_axi_rlast;
      @(negedge clk);
    end
    chk("bp_beats", 128'(idx), 128'd8);
    s_axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_no_extra", 128'(s_axi_rvalid), 128'd0);

    // Back-to-back: second AR held throughout first burst
    s_axi_rready = 1'b1;
    do_ar(w(20), 8'd1, SIZE_16B, BURST_INCR, 4'd1);
    s_axi_araddr  = w(40);
    s_axi_arlen   = 8'd0;
    s_axi_arid    = 4'd2;
    s_axi_arvalid = 1'b1;
    tl = 0;
    ta = -100;
    for (int c = 0; c < 20; c++) begin
      if (s_axi_rvalid && s_axi_rlast && s_axi_rid == 4'd1)
        tl = cyc_cnt + 1;
      if (s_axi_arvalid && s_axi_arready) begin
        ta = cyc_cnt + 1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_gap", 128'(ta - tl), 128'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (s_axi_rvalid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_seen", 128'(seen), 128'd1);
    chk("b2b_data", s_axi_rdata, 128'd40);
    chk("b2b_rid", 128'(s_axi_rid), 128'd2);
    chk("b2b_last", 128'(s_axi_rlast), 128'd1);
    @(negedge clk);

    // Reset pulse mid-burst
    s_axi_rready = 1'b1;
    do_ar(w(32), 8'd7, SIZE_16B, BURST_INCR, 4'd7);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      @(negedge clk);
      if (s_axi_rvalid) cnt++;
    end
    chk("mid_beats", 128'(cnt), 128'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("mid_rst_arready", 128'(s_axi_arready), 128'd0);
    chk("mid_rst_mem_en", 128'(mem_en), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_arready", 128'(s_axi_arready), 128'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (s_axi_rvalid) seen = 1;
      @(negedge clk);
    end
    chk("mid_no_stale", 128'(seen), 128'd0);
    run_burst(vt[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
